// File: rtl/swipt_link_ctrl.sv
// Retrying half-duplex SWIPT link controller: frames one command word, shifts it out
// bit-serially, then runs a blind/listen receive window with timeout and bounded retry.
module swipt_link_ctrl #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       BIT_PERIOD  = 200000,
    parameter int unsigned       BLIND_CYC   = 1000000,
    parameter int unsigned       TIMEOUT_CYC = 10000000,
    parameter int unsigned       MAX_RETRY   = 3,
    parameter int unsigned       PRE_W       = 6,
    parameter logic [PRE_W-1:0]  PRE         = 6'b101010,
    parameter int unsigned       POST_W      = 4,
    parameter logic [POST_W-1:0] POST        = 4'b0101
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_enable,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [1:0]        i_tx_mode,
    input  logic [1:0]        i_tx_type,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_dout,
    output logic              o_write,
    output logic              o_read,
    output logic              o_rx_en,
    input  logic              i_rx_ready,
    input  logic              i_rx_ok,
    output logic              o_done,
    output logic              o_fail,
    output logic [3:0]        o_retry_cnt
);

    localparam int unsigned FRAME_W = PRE_W + 4 + DATA_W + 1 + POST_W;
    localparam int unsigned CNT_W   = $clog2(BIT_PERIOD + 1);
    localparam int unsigned BITS_W  = $clog2(FRAME_W);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StTx, StBlind, StListen} state_e;

    state_e             r_state, w_state;
    logic [FRAME_W-1:0] r_frame, w_frame;
    logic [FRAME_W-1:0] r_shift, w_shift;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [BITS_W-1:0]  r_bits, w_bits;
    logic [TMO_W-1:0]   r_tmo, w_tmo;
    logic [3:0]         r_retry, w_retry;
    logic               r_done, w_done;
    logic               r_fail, w_fail;
    logic               w_retry_ev;
    logic [FRAME_W-1:0] w_frame_in;

    assign w_frame_in = {PRE, i_tx_mode, i_tx_type, i_tx_data, ^i_tx_data, POST};

    always_comb begin
        w_state    = r_state;
        w_frame    = r_frame;
        w_shift    = r_shift;
        w_cnt      = r_cnt;
        w_bits     = r_bits;
        w_tmo      = r_tmo;
        w_retry    = r_retry;
        w_done     = 1'b0;
        w_fail     = 1'b0;
        w_retry_ev = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_tx_valid) begin
                    w_frame = w_frame_in;
                    w_shift = w_frame_in;
                    w_retry = '0;
                    w_cnt   = '0;
                    w_bits  = '0;
                    w_state = StTx;
                end
            end
            StTx: begin
                if (r_cnt == CNT_W'(BIT_PERIOD - 1)) begin
                    w_cnt = '0;
                    if (r_bits == BITS_W'(FRAME_W - 1)) begin
                        w_tmo   = '0;
                        w_state = StBlind;
                    end else begin
                        w_bits  = r_bits + 1'b1;
                        w_shift = {r_shift[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StBlind: begin
                w_tmo = r_tmo + 1'b1;
                if (r_tmo == TMO_W'(BLIND_CYC - 1)) begin
                    w_state = StListen;
                end
            end
            StListen: begin
                w_tmo = r_tmo + 1'b1;
                // A reply in the timeout cycle wins over the timeout.
                if (i_rx_ready && i_rx_ok) begin
                    w_done  = 1'b1;
                    w_state = StIdle;
                end else if (i_rx_ready || (r_tmo == TMO_W'(TIMEOUT_CYC - 1))) begin
                    w_retry_ev = 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase

        if (w_retry_ev) begin
            if (r_retry < 4'(MAX_RETRY)) begin
                w_retry = r_retry + 1'b1;
                w_shift = r_frame;
                w_cnt   = '0;
                w_bits  = '0;
                w_state = StTx;
            end else begin
                w_fail  = 1'b1;
                w_state = StIdle;
            end
        end

        if (!i_enable) begin
            w_state = StIdle;
            w_frame = '0;
            w_shift = '0;
            w_cnt   = '0;
            w_bits  = '0;
            w_tmo   = '0;
            w_retry = '0;
            w_done  = 1'b0;
            w_fail  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= StIdle;
            r_frame <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_tmo   <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_frame <= w_frame;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            r_bits  <= w_bits;
            r_tmo   <= w_tmo;
            r_retry <= w_retry;
            r_done  <= w_done;
            r_fail  <= w_fail;
        end
    end

    assign o_tx_ready  = (r_state == StIdle);
    assign o_write     = (r_state == StTx);
    assign o_dout      = (r_state == StTx) & r_shift[FRAME_W-1];
    assign o_read      = (r_state == StBlind) || (r_state == StListen);
    assign o_rx_en     = (r_state == StListen);
    assign o_done      = r_done;
    assign o_fail      = r_fail;
    assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_swipt_link_ctrl.sv
// Scoreboard bench for swipt_link_ctrl: expected serial bits and done/fail outcomes are
// queued when stimulus is driven and popped by a negedge monitor as the DUT produces them.
module tb_swipt_link_ctrl;

    localparam int DATA_W      = 8;
    localparam int BIT_PERIOD  = 4;
    localparam int BLIND_CYC   = 3;
    localparam int TIMEOUT_CYC = 20;
    localparam int MAX_RETRY   = 1;
    localparam int FRAME_W     = 23;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              enable = 1'b1;
    logic              tx_valid = 1'b0;
    logic [1:0]        tx_mode = '0;
    logic [1:0]        tx_type = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              rx_ready = 1'b0;
    logic              rx_ok = 1'b0;
    logic              o_tx_ready, o_dout, o_write, o_read, o_rx_en, o_done, o_fail;
    logic [3:0]        o_retry_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_bits[$];
    logic [5:0] exp_out[$];

    always #5 clk = ~clk;

    swipt_link_ctrl #(
        .DATA_W      (DATA_W),
        .BIT_PERIOD  (BIT_PERIOD),
        .BLIND_CYC   (BLIND_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) u_dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_enable    (enable),
        .i_tx_valid  (tx_valid),
        .o_tx_ready  (o_tx_ready),
        .i_tx_mode   (tx_mode),
        .i_tx_type   (tx_type),
        .i_tx_data   (tx_data),
        .o_dout      (o_dout),
        .o_write     (o_write),
        .o_read      (o_read),
        .o_rx_en     (o_rx_en),
        .i_rx_ready  (rx_ready),
        .i_rx_ok     (rx_ok),
        .o_done      (o_done),
        .o_fail      (o_fail),
        .o_retry_cnt (o_retry_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] frame_of(input logic [1:0] m, input logic [1:0] t,
                                                    input logic [7:0] d);
        return {6'b101010, m, t, d, ^d, 4'b0101};
    endfunction

    task automatic push_frame(input logic [FRAME_W-1:0] f);
        for (int i = FRAME_W - 1; i >= 0; i--) begin
            for (int j = 0; j < BIT_PERIOD; j++) exp_bits.push_back(f[i]);
        end
    endtask

    task automatic run_monitor();
        logic       eb;
        logic [5:0] eo;
        forever begin
            @(negedge clk);
            if (o_write === 1'b1) begin
                n_cmp++;
                if (exp_bits.size() == 0) begin
                    n_bad++;
                    $display("FAIL dout_extra: write=1 dout=%b with no frame bit expected", o_dout);
                end else begin
                    eb = exp_bits.pop_front();
                    if (o_dout !== eb) begin
                        n_bad++;
                        $display("FAIL dout_bit: dout=%b required %b at %0t", o_dout, eb, $time);
                    end
                end
            end
            if (o_done === 1'b1 || o_fail === 1'b1) begin
                n_cmp++;
                if (exp_out.size() == 0) begin
                    n_bad++;
                    $display("FAIL outcome_extra: done=%b fail=%b with no outcome expected",
                             o_done, o_fail);
                end else begin
                    eo = exp_out.pop_front();
                    if ({o_done, o_fail, o_retry_cnt} !== eo) begin
                        n_bad++;
                        $display("FAIL outcome: {done,fail,retry}=%b required %b",
                                 {o_done, o_fail, o_retry_cnt}, eo);
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [1:0] t, input logic [7:0] d);
        n_cmp++;
        if (o_tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: tx_ready=%b required 1", o_tx_ready);
        end
        tx_mode  = m;
        tx_type  = t;
        tx_data  = d;
        tx_valid = 1'b1;
        push_frame(frame_of(m, t, d));
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_write_end(output int n);
        n = 0;
        while (o_write === 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rx_en(output int n);
        n = 0;
        while (o_rx_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_read_end(output int n);
        n = 0;
        while (o_read === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({o_tx_ready, o_dout, o_write, o_read, o_rx_en, o_done, o_fail, o_retry_cnt}
            !== 11'b1_000000_0000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 10000000000",
                     {o_tx_ready, o_dout, o_write, o_read, o_rx_en, o_done, o_fail, o_retry_cnt});
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_frame_ack();
        int n;
        send(2'b01, 2'b10, 8'hA5);
        n_cmp++;
        if ({o_write, o_dout, o_tx_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL first_bit: {write,dout,tx_ready}=%b required 110",
                     {o_write, o_dout, o_tx_ready});
        end
        wait_write_end(n);
        n_cmp++;
        if (n !== 92) begin n_bad++; $display("FAIL write_len: %0d cycles required 92", n); end
        n_cmp++;
        if ({o_read, o_dout, o_rx_en} !== 3'b100) begin
            n_bad++;
            $display("FAIL read_rise: {read,dout,rx_en}=%b required 100", {o_read, o_dout, o_rx_en});
        end
        wait_rx_en(n);
        n_cmp++;
        if (n !== BLIND_CYC) begin n_bad++; $display("FAIL blind_len: %0d required 3", n); end
        tick();
        rx_ready = 1'b1;
        rx_ok    = 1'b1;
        exp_out.push_back({1'b1, 1'b0, 4'd0});
        tick();
        rx_ready = 1'b0;
        rx_ok    = 1'b0;
        n_cmp++;
        if ({o_done, o_tx_ready, o_read, o_rx_en, o_retry_cnt} !== 8'b1100_0000) begin
            n_bad++;
            $display("FAIL ack_done: {done,tx_ready,read,rx_en,retry}=%b required 11000000",
                     {o_done, o_tx_ready, o_read, o_rx_en, o_retry_cnt});
        end
        tick();
        n_cmp++;
        if (o_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: done=%b required 0", o_done); end
    endtask

    task automatic test_timeout_retry();
        int n;
        send(2'b01, 2'b10, 8'hA5);
        tx_mode = 2'b10;
        tx_type = 2'b01;
        tx_data = 8'h3C;
        wait_write_end(n);
        wait_read_end(n);
        n_cmp++;
        if (n !== TIMEOUT_CYC) begin n_bad++; $display("FAIL timeout_len1: %0d required 20", n); end
        push_frame(frame_of(2'b01, 2'b10, 8'hA5));
        n_cmp++;
        if ({o_write, o_dout, o_retry_cnt, o_fail, o_done} !== 8'b11_0001_00) begin
            n_bad++;
            $display("FAIL retx_start: {write,dout,retry,fail,done}=%b required 11000100",
                     {o_write, o_dout, o_retry_cnt, o_fail, o_done});
        end
        wait_write_end(n);
        n_cmp++;
        if (n !== 92) begin n_bad++; $display("FAIL retx_len: %0d cycles required 92", n); end
        exp_out.push_back({1'b0, 1'b1, 4'd1});
        wait_read_end(n);
        n_cmp++;
        if (n !== TIMEOUT_CYC) begin n_bad++; $display("FAIL timeout_len2: %0d required 20", n); end
        n_cmp++;
        if ({o_fail, o_tx_ready, o_write, o_retry_cnt} !== 7'b110_0001) begin
            n_bad++;
            $display("FAIL fail_pulse: {fail,tx_ready,write,retry}=%b required 1100001",
                     {o_fail, o_tx_ready, o_write, o_retry_cnt});
        end
        tick();
        n_cmp++;
        if ({o_fail, o_retry_cnt} !== 5'b0_0001) begin
            n_bad++;
            $display("FAIL retry_hold: {fail,retry}=%b required 00001", {o_fail, o_retry_cnt});
        end
    endtask

    task automatic test_nack_retry();
        int n;
        send(2'b00, 2'b11, 8'h5A);
        wait_write_end(n);
        rx_ready = 1'b1;
        rx_ok    = 1'b0;
        tick();
        rx_ready = 1'b0;
        wait_rx_en(n);
        n_cmp++;
        if ((n + 1) !== BLIND_CYC || o_write !== 1'b0) begin
            n_bad++;
            $display("FAIL blind_ignore: blind=%0d write=%b required 3 and 0", n + 1, o_write);
        end
        rx_ready = 1'b1;
        rx_ok    = 1'b0;
        push_frame(frame_of(2'b00, 2'b11, 8'h5A));
        tick();
        rx_ready = 1'b0;
        n_cmp++;
        if ({o_write, o_read, o_rx_en, o_retry_cnt} !== 7'b100_0001) begin
            n_bad++;
            $display("FAIL nack_retx: {write,read,rx_en,retry}=%b required 1000001",
                     {o_write, o_read, o_rx_en, o_retry_cnt});
        end
        wait_write_end(n);
        wait_rx_en(n);
        exp_out.push_back({1'b1, 1'b0, 4'd1});
        rx_ready = 1'b1;
        rx_ok    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_ok    = 1'b0;
        n_cmp++;
        if ({o_done, o_retry_cnt, o_tx_ready} !== 6'b1_0001_1) begin
            n_bad++;
            $display("FAIL nack_ack: {done,retry,tx_ready}=%b required 100011",
                     {o_done, o_retry_cnt, o_tx_ready});
        end
        tick();
    endtask

    task automatic test_abort();
        int n;
        send(2'b11, 2'b01, 8'hF0);
        repeat (10 * BIT_PERIOD) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({o_write, o_dout, o_tx_ready, o_read, o_rx_en, o_done, o_fail, o_retry_cnt}
            !== 11'b0010000_0000) begin
            n_bad++;
            $display("FAIL enable_abort: got %b required 00100000000",
                     {o_write, o_dout, o_tx_ready, o_read, o_rx_en, o_done, o_fail, o_retry_cnt});
        end
        exp_bits.delete();
        enable = 1'b1;
        repeat (10) tick();
        send(2'b01, 2'b01, 8'h81);
        wait_write_end(n);
        wait_rx_en(n);
        repeat (2) tick();
        nrst = 1'b0;
        tick();
        n_cmp++;
        if ({o_write, o_dout, o_tx_ready, o_read, o_rx_en, o_done, o_fail, o_retry_cnt}
            !== 11'b0010000_0000) begin
            n_bad++;
            $display("FAIL nrst_abort: got %b required 00100000000",
                     {o_write, o_dout, o_tx_ready, o_read, o_rx_en, o_done, o_fail, o_retry_cnt});
        end
        nrst = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if ({o_write, o_read, o_tx_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL abort_idle: {write,read,tx_ready}=%b required 001",
                     {o_write, o_read, o_tx_ready});
        end
    endtask

    task automatic test_simultaneous();
        int n;
        send(2'b10, 2'b00, 8'h07);
        wait_write_end(n);
        repeat (TIMEOUT_CYC - 1) tick();
        n_cmp++;
        if ({o_read, o_rx_en} !== 2'b11) begin
            n_bad++;
            $display("FAIL last_listen: {read,rx_en}=%b required 11", {o_read, o_rx_en});
        end
        exp_out.push_back({1'b1, 1'b0, 4'd0});
        rx_ready = 1'b1;
        rx_ok    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_ok    = 1'b0;
        n_cmp++;
        if ({o_done, o_write, o_retry_cnt, o_tx_ready} !== 7'b10_0000_1) begin
            n_bad++;
            $display("FAIL ack_vs_timeout: {done,write,retry,tx_ready}=%b required 1000001",
                     {o_done, o_write, o_retry_cnt, o_tx_ready});
        end
        repeat (30) tick();
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_frame_ack();
        test_timeout_retry();
        test_nack_retry();
        test_abort();
        test_simultaneous();
        n_cmp++;
        if (exp_bits.size() != 0 || exp_out.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d bits and %0d outcomes left, required 0 and 0",
                     exp_bits.size(), exp_out.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
